// File: rtl/cpu_bus_interconnect.sv
// rtl/cpu_bus_interconnect.sv - picorv32 native bus decoder and response mux
// Optional feature macro: BUS_TIMEOUT_EN (abort ACCESS after TIMEOUT_CYCLES, error code 10)
module cpu_bus_interconnect #(
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE =
    {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {NUM_SLAVES{32'hFFFF_F000}},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       cpu_valid_i,
  input  logic [31:0]                cpu_addr_i,
  input  logic [31:0]                cpu_wdata_i,
  input  logic [3:0]                 cpu_wstrb_i,
  output logic                       cpu_ready_o,
  output logic [31:0]                cpu_rdata_o,
  output logic [NUM_SLAVES-1:0]      s_valid_o,
  output logic [31:0]                s_addr_o,
  output logic [31:0]                s_wdata_o,
  output logic [3:0]                 s_wstrb_o,
  input  logic [NUM_SLAVES-1:0]      s_ready_i,
  input  logic [NUM_SLAVES*32-1:0]   s_rdata_i,
  output logic                       err_o,
  output logic [1:0]                 err_code_o,
  output logic [31:0]                err_addr_o,
  input  logic                       err_clr_i
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, HOLD} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        sel;
  logic                    hit;
  logic [IDX_W-1:0]        hit_idx;
  logic [NUM_SLAVES-1:0]   hit_onehot;
  logic                    sel_ready;
  logic [31:0]             sel_rdata;
  logic                    err_load;

  // Address decode; scanning downwards lets the lowest matching index win
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    hit_onehot = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((cpu_addr_i & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    if (hit) hit_onehot[hit_idx] = 1'b1;
  end

  // Only the selected slave's ready/data are observed; others are ignored
  assign sel_ready = s_ready_i[sel];
  assign sel_rdata = s_rdata_i[32*sel +: 32];

  // First error is kept until cleared; a clear in the same cycle lets a new error load
  assign err_load = !err_o || err_clr_i;

`ifdef BUS_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_hit;
  assign tmo_hit = (32'(tmo_cnt) + 32'd1) == 32'(TIMEOUT_CYCLES);
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

  // Transaction FSM with registered bus outputs and sticky error capture
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      sel         <= '0;
      cpu_ready_o <= 1'b0;
      cpu_rdata_o <= '0;
      s_valid_o   <= '0;
      s_addr_o    <= '0;
      s_wdata_o   <= '0;
      s_wstrb_o   <= '0;
      err_o       <= 1'b0;
      err_code_o  <= 2'b00;
      err_addr_o  <= '0;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      cpu_ready_o <= 1'b0;
      if (err_clr_i) begin
        err_o      <= 1'b0;
        err_code_o <= 2'b00;
        err_addr_o <= '0;
      end
      case (state)
        IDLE: begin
          if (cpu_valid_i) begin
            s_addr_o  <= cpu_addr_i;
            s_wdata_o <= cpu_wdata_i;
            s_wstrb_o <= cpu_wstrb_i;
            if (hit) begin
              sel       <= hit_idx;
              s_valid_o <= hit_onehot;
              state     <= ACCESS;
`ifdef BUS_TIMEOUT_EN
              tmo_cnt   <= '0;
`endif
            end else begin
              cpu_rdata_o <= '0;
              cpu_ready_o <= 1'b1;
              if (err_load) begin
                err_o      <= 1'b1;
                err_code_o <= 2'b01;
                err_addr_o <= cpu_addr_i;
              end
              state <= RESP;
            end
          end
        end
        ACCESS: begin
          if (sel_ready) begin
            cpu_rdata_o <= sel_rdata;
            cpu_ready_o <= 1'b1;
            s_valid_o   <= '0;
            state       <= RESP;
          end
`ifdef BUS_TIMEOUT_EN
          else if (tmo_hit) begin
            cpu_rdata_o <= 32'hFFFF_FFFF;
            cpu_ready_o <= 1'b1;
            s_valid_o   <= '0;
            if (err_load) begin
              err_o      <= 1'b1;
              err_code_o <= 2'b10;
              err_addr_o <= s_addr_o;
            end
            state <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end
        RESP:    state <= HOLD;
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
